// File: rtl/awgn_add.sv
// rtl/awgn_add.sv - two-stage AWGN injector: LFSR noise, scaled, saturating add, frame EOF tagging
module awgn_add #(
    parameter int          FRAME_LEN = 480,
    parameter logic [15:0] SEED_RE   = 16'h1D2B,
    parameter logic [15:0] SEED_IM   = 16'hACE1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    input  logic        noise_en,
    input  logic [3:0]  noise_scale,
    output logic [31:0] DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    output logic        EOF_O
);

    localparam int          CW      = ($clog2(FRAME_LEN) > 9) ? $clog2(FRAME_LEN) : 9;
    localparam logic [CW-1:0] LAST  = CW'(FRAME_LEN - 1);
    // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form
    localparam logic [15:0] TAPS    = 16'hB400;
    // An all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [15:0] INIT_RE = (SEED_RE == 16'h0000) ? 16'h0001 : SEED_RE;
    localparam logic [15:0] INIT_IM = (SEED_IM == 16'h0000) ? 16'h0001 : SEED_IM;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? TAPS : 16'h0000);
    endfunction

    function automatic logic [15:0] scale_noise(input logic [15:0] s, input logic [3:0] sh);
        return 16'($signed(s) >>> sh);
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        if (sum[16] != sum[15])
            return sum[16] ? 16'h8000 : 16'h7FFF;
        return sum[15:0];
    endfunction

    logic          halt;
    logic          accept;
    logic          cyc_q;
    logic          cyc_rise;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [15:0]   lfsr_re;
    logic [15:0]   lfsr_im;

    logic          v1;
    logic          eof1;
    logic [15:0]   re1;
    logic [15:0]   im1;
    logic [15:0]   nre1;
    logic [15:0]   nim1;

    // A stalled output freezes the whole pipe; acceptance is blocked in reset
    assign halt     = STB_O & ~ACK_I;
    assign accept   = RST_I & CYC_I & STB_I & WE_I & ~halt;
    assign ACK_O    = accept;
    assign WE_O     = STB_O;
    assign cyc_rise = CYC_I & ~cyc_q;
    assign idx      = cyc_rise ? '0 : cnt;

    // Stage 1: capture sample and its noise, step LFSRs and frame counter
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            cyc_q   <= 1'b0;
            cnt     <= '0;
            lfsr_re <= INIT_RE;
            lfsr_im <= INIT_IM;
            v1      <= 1'b0;
            eof1    <= 1'b0;
            re1     <= '0;
            im1     <= '0;
            nre1    <= '0;
            nim1    <= '0;
        end else if (!halt) begin
            cyc_q <= CYC_I;
            v1    <= accept;
            if (accept) begin
                re1     <= DAT_I[15:0];
                im1     <= DAT_I[31:16];
                nre1    <= noise_en ? scale_noise(lfsr_re, noise_scale) : 16'h0000;
                nim1    <= noise_en ? scale_noise(lfsr_im, noise_scale) : 16'h0000;
                eof1    <= (idx == LAST);
                cnt     <= (idx == LAST) ? '0 : idx + 1'b1;
                lfsr_re <= lfsr_next(lfsr_re);
                lfsr_im <= lfsr_next(lfsr_im);
            end else if (cyc_rise) begin
                cnt <= '0;
            end
        end
    end

    // Stage 2: saturating add into the output register, bus cycle tracking
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            DAT_O <= '0;
            STB_O <= 1'b0;
            EOF_O <= 1'b0;
            CYC_O <= 1'b0;
        end else begin
            if (!halt) begin
                STB_O <= v1;
                EOF_O <= v1 & eof1;
                if (v1)
                    DAT_O <= {sat_add(im1, nim1), sat_add(re1, nre1)};
            end
            if (!halt && v1)
                CYC_O <= 1'b1;
            else if (!CYC_I && !v1 && !STB_O)
                CYC_O <= 1'b0;
        end
    end

endmodule

// File: tb/tb_awgn_add.sv
// tb/tb_awgn_add.sv - scoreboard bench for awgn_add
module tb_awgn_add;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [31:0] DAT_I;
    logic [31:0] dat_n_i;
    logic        CYC_I, STB_I, WE_I, ACK_I;
    logic        noise_en;
    logic [3:0]  noise_scale;

    logic        ACK_O, CYC_O, STB_O, WE_O, EOF_O;
    logic [31:0] DAT_O;
    logic        ack_p, cyc_p, stb_p, we_p, eof_p;
    logic [31:0] dat_p;
    logic        ack_n, cyc_n, stb_n, we_n, eof_n;
    logic [31:0] dat_n;

    awgn_add dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
        .ACK_O(ACK_O), .noise_en(noise_en), .noise_scale(noise_scale), .DAT_O(DAT_O),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I), .EOF_O(EOF_O)
    );

    awgn_add #(.SEED_RE(16'h7FFF)) dut_p (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
        .ACK_O(ack_p), .noise_en(noise_en), .noise_scale(noise_scale), .DAT_O(dat_p),
        .CYC_O(cyc_p), .STB_O(stb_p), .WE_O(we_p), .ACK_I(ACK_I), .EOF_O(eof_p)
    );

    awgn_add #(.SEED_RE(16'h8000)) dut_n (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(dat_n_i), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
        .ACK_O(ack_n), .noise_en(noise_en), .noise_scale(noise_scale), .DAT_O(dat_n),
        .CYC_O(cyc_n), .STB_O(stb_n), .WE_O(we_n), .ACK_I(ACK_I), .EOF_O(eof_n)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic [31:0] dat;
        logic        eof;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cycle = 0;
    int          eof_seen = 0;
    bit          lat_chk = 0;

    logic [15:0] m_re, m_im;
    int          m_cnt;
    logic        m_cyc;
    logic        was_halt;
    logic [31:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [15:0] m_noise(input logic [15:0] s, input logic en, input logic [3:0] sh);
        int v;
        if (!en) return 16'h0000;
        v = int'($signed(s));
        v = v >>> sh;
        return 16'(v);
    endfunction

    function automatic logic [15:0] m_sat(input logic [15:0] a, input logic [15:0] n);
        int s;
        s = int'($signed(a)) + int'($signed(n));
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    always @(posedge CLK_I) cycle <= cycle + 1;

    // Reference model and scoreboard, evaluated mid-cycle
    always @(negedge CLK_I) begin
        logic halt_m, exp_ack, rise;
        int   idx;
        exp_t e;
        if (!RST_I) begin
            chk("rst_dat", DAT_O, 32'h0);
            chk("rst_stb", {31'h0, STB_O}, 32'h0);
            chk("rst_ack", {31'h0, ACK_O}, 32'h0);
            chk("rst_cyc_eof", {30'h0, CYC_O, EOF_O}, 32'h0);
            sb.delete();
            m_re = 16'h1D2B; m_im = 16'hACE1;
            m_cnt = 0; m_cyc = 1'b0; was_halt = 1'b0;
        end else begin
            halt_m  = STB_O & ~ACK_I;
            exp_ack = CYC_I & STB_I & WE_I & ~halt_m;
            chk("ack", {31'h0, ACK_O}, {31'h0, exp_ack});
            if (STB_O) chk("cyc_we_o", {30'h0, CYC_O, WE_O}, 32'h3);
            if (halt_m) begin
                if (was_halt) chk("hold_dat", DAT_O, held);
                held = DAT_O;
            end
            was_halt = halt_m;
            if (STB_O && ACK_I) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("dat", DAT_O, e.dat);
                    chk("eof", {31'h0, EOF_O}, {31'h0, e.eof});
                    if (lat_chk) chk("latency", cycle - e.cyc, 32'd2);
                    if (EOF_O) eof_seen++;
                end
            end
            rise = 1'b0;
            if (!halt_m) begin
                rise  = CYC_I & ~m_cyc;
                m_cyc = CYC_I;
            end
            if (exp_ack) begin
                idx   = rise ? 0 : m_cnt;
                e.dat = {m_sat(DAT_I[31:16], m_noise(m_im, noise_en, noise_scale)),
                         m_sat(DAT_I[15:0],  m_noise(m_re, noise_en, noise_scale))};
                e.eof = (idx == 479);
                e.cyc = cycle;
                sb.push_back(e);
                m_cnt = (idx == 479) ? 0 : idx + 1;
                m_re  = m_step(m_re);
                m_im  = m_step(m_im);
            end else if (rise) begin
                m_cnt = 0;
            end
        end
    end

    task automatic send(input logic [31:0] d);
        logic got;
        got = 1'b0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; DAT_I = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK_I);
            got = ACK_O;
            @(posedge CLK_I);
            #1;
            if (got) break;
        end
        if (!got) chk("ack_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain(input string tag);
        STB_I = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(posedge CLK_I);
            #1;
        end
        chk(tag, sb.size(), 32'h0);
    endtask

    task automatic wait_stb_p();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK_I);
            if (stb_p) break;
        end
        chk("sat_stb", {31'h0, stb_p}, 32'h1);
    endtask

    initial begin
        RST_I = 1'b0; CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ACK_I = 1'b1;
        noise_en = 1'b0; noise_scale = 4'd0; DAT_I = 32'hFFFF_FFFF; dat_n_i = 32'h0;
        repeat (3) @(posedge CLK_I);
        #1;
        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1;

        // Pass-through frame, EOF only on the last sample, fixed latency
        lat_chk = 1;
        for (int i = 0; i < 480; i++) send(32'h1234_5678);
        drain("drain_a");
        lat_chk = 0;
        chk("eof_count_a", eof_seen, 32'd1);
        CYC_I = 1'b0;
        repeat (4) @(posedge CLK_I);
        #1;
        chk("cyc_o_idle", {31'h0, CYC_O}, 32'h0);

        // Noisy random stream with changing controls and a 5-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    noise_en    = 1'($urandom_range(0, 3) != 0);
                    noise_scale = 4'($urandom_range(0, 15));
                    send($urandom);
                end
            end
            begin
                repeat (20) @(posedge CLK_I);
                #1;
                ACK_I = 1'b0;
                repeat (5) @(posedge CLK_I);
                #1;
                ACK_I = 1'b1;
            end
        join
        drain("drain_b");
        CYC_I = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1;

        // Reset mid-frame, then a full frame from the seed sequence
        noise_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            noise_scale = 4'($urandom_range(0, 15));
            send($urandom);
        end
        RST_I = 1'b0;
        repeat (3) @(posedge CLK_I);
        #1;
        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1;
        eof_seen = 0;
        for (int i = 0; i < 480; i++) begin
            noise_scale = 4'($urandom_range(0, 15));
            send($urandom);
        end
        drain("drain_c");
        chk("eof_count_c", eof_seen, 32'd1);
        CYC_I = 1'b0;

        // Saturation at the extreme seeds, first sample after reset
        RST_I = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        @(posedge CLK_I);
        #1;
        noise_en = 1'b1; noise_scale = 4'd0; dat_n_i = 32'h0000_9000;
        send(32'h0000_7000);
        STB_I = 1'b0;
        wait_stb_p();
        chk("sat_pos", {16'h0, dat_p[15:0]}, 32'h7FFF);
        chk("sat_neg", {16'h0, dat_n[15:0]}, 32'h8000);
        @(posedge CLK_I);
        #1;
        CYC_I = 1'b0;
        RST_I = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        @(posedge CLK_I);
        #1;
        noise_scale = 4'd15;
        send(32'h0000_7000);
        STB_I = 1'b0;
        wait_stb_p();
        chk("scale15_neg", {16'h0, dat_n[15:0]}, 32'h8FFF);
        chk("scale15_pos", {16'h0, dat_p[15:0]}, 32'h7000);
        drain("drain_d");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
